// File: rtl/sync_bank_pkg.sv
// Shared constants and helpers for the sync_bank synchronizer bank.
// Filter counter width is derived here so top and any users agree on it.
package sync_pkg;

    localparam int STAGES_DEF = 2;
    localparam int FILTER_DEF = 4;

    // Counter must hold 0..FILTER-1; never narrower than one bit.
    function automatic int cnt_width(input int filter);
        int w;
        w = $clog2(filter + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_bank_chain.sv
// Vector N-stage flip-flop synchronizer with synchronous active-high reset.
// Only s_q[1] reads s_q[0]; the first stage is the one allowed to go metastable.
module sync_chain
    import sync_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = STAGES_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] s_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q <= {STAGES{RESET_VAL}};
        end else begin
            s_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                s_q[i] <= s_q[i-1];
            end
        end
    end

    assign sync_o = s_q[STAGES-1];

endmodule

// File: rtl/sync_bank.sv
// Synchronizer bank: per-channel sync chain, optional debounce, edge pulses.
// Define SYNC_BANK_FILTER_EN to build the stability counters; otherwise level tracks synced.
module sync_bank
    import sync_pkg::*;
#(
    parameter int                  CHANNELS  = 8,
    parameter int                  STAGES    = STAGES_DEF,
    parameter int                  FILTER    = FILTER_DEF,
    parameter logic [CHANNELS-1:0] RESET_VAL = {CHANNELS{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("sync_bank: CHANNELS must be >= 1");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_bank: STAGES must be >= 2");
    end
    if (FILTER < 1) begin : g_bad_filter
        $error("sync_bank: FILTER must be >= 1");
    end

    logic [CHANNELS-1:0] synced;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic                changed_q;

    sync_chain #(
        .WIDTH     (CHANNELS),
        .STAGES    (STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_chain (
        .clk_i   (clock),
        .rst_i   (reset),
        .async_i (async_in),
        .sync_o  (synced)
    );

`ifdef SYNC_BANK_FILTER_EN
    localparam int            CW       = cnt_width(FILTER);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic lvl_d;
`ifdef SYNC_BANK_FILTER_EN
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Count consecutive disagreeing cycles; commit on the FILTER-th one.
        always_comb begin
            cnt_d = '0;
            lvl_d = level_q[g];
            if (synced[g] != level_q[g]) begin
                if (cnt_q == CNT_LAST) begin
                    lvl_d = synced[g];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
`else
        assign lvl_d = synced[g];
`endif
        assign level_d[g] = lvl_d;
    end

    // Edges registered with level so a pulse coincides with the new level.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q   <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            rise_q    <= ~level_q & level_d;
            fall_q    <= level_q & ~level_d;
            changed_q <= |(level_q ^ level_d);
        end
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule
